// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, state enum and write-port type for the weight/bias loader
package wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 11;
  localparam int BANK_W   = 6;
  localparam int L1_BANKS = 32;
  localparam int L1_DEPTH = 785;
  localparam int L2_BANKS = 10;
  localparam int L2_DEPTH = 33;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK
  } state_t;

  typedef struct packed {
    logic              en;
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/wb_addr_gen.sv
// rtl/wb_addr_gen.sv - bank-major bank/address counter pair for the weight banks
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load              clear both counters (start of a new sequence)
//   step              advance to the next word
//   nbanks, depth     shape of the current sequence (banks x words per bank)
//   bank_cnt          bank offset relative to the sequence base
//   addr_cnt          word address inside the current bank
//   wrap              addr_cnt is on the last word of a bank
//   last              counters point at the final word of the sequence
module wb_addr_gen
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [BANK_W-1:0] nbanks,
  input  logic [ADDR_W-1:0] depth,
  output logic [BANK_W-1:0] bank_cnt,
  output logic [ADDR_W-1:0] addr_cnt,
  output logic              wrap,
  output logic              last
);

  assign wrap = (addr_cnt == depth - ADDR_W'(1));
  assign last = wrap && (bank_cnt == nbanks - BANK_W'(1));

  always_ff @(posedge clk) begin
    if (reset || load) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
    end else if (step) begin
      if (wrap) begin
        addr_cnt <= '0;
        bank_cnt <= bank_cnt + BANK_W'(1);
      end else begin
        addr_cnt <= addr_cnt + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/wb_loader.sv
// rtl/wb_loader.sv - stream-to-bank writer for the layer-1/layer-2 weight store with checksum
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, layer_sel  begin a load of layer 1 (0) or layer 2 (1); honoured only when idle
//   abort             cancel the load in progress, flags err
//   s_valid, s_data   incoming word stream; s_ready is high whenever a load is active
//   wr_en, wr_bank,
//   wr_addr, wr_data  registered bank write port, one cycle after each accepted word
//   busy              a load is in progress
//   done              one-cycle pulse after the checksum word is consumed
//   err               sticky: checksum mismatch or abort, cleared by the next start
module wb_loader
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              layer_sel,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [BANK_W-1:0] wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  wr_port_t          wr;
  logic [BANK_W-1:0] base;
  logic [BANK_W-1:0] nbanks;
  logic [ADDR_W-1:0] depth;
  logic [DATA_W-1:0] sum;
  logic [BANK_W-1:0] bank_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              wrap;
  logic              last;
  logic              accept;

  assign s_ready = (state != IDLE);
  assign busy    = (state != IDLE);
  // A word offered in the same cycle as abort is dropped entirely.
  assign accept  = s_valid && s_ready && !abort;

  assign wr_en   = wr.en;
  assign wr_bank = wr.bank;
  assign wr_addr = wr.addr;
  assign wr_data = wr.data;

  wb_addr_gen u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == IDLE) && start),
    // Counters stay parked on the final word so the checksum cycle sees them unchanged.
    .step     ((state == LOAD) && accept && !last),
    .nbanks   (nbanks),
    .depth    (depth),
    .bank_cnt (bank_cnt),
    .addr_cnt (addr_cnt),
    .wrap     (wrap),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wr     <= '0;
      base   <= '0;
      nbanks <= '0;
      depth  <= '0;
      sum    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      wr.en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base   <= layer_sel ? BANK_W'(L1_BANKS) : '0;
            nbanks <= layer_sel ? BANK_W'(L2_BANKS) : BANK_W'(L1_BANKS);
            depth  <= layer_sel ? ADDR_W'(L2_DEPTH) : ADDR_W'(L1_DEPTH);
            sum    <= '0;
            err    <= 1'b0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (accept) begin
            sum     <= sum + s_data;
            wr.en   <= 1'b1;
            wr.bank <= base + bank_cnt;
            wr.addr <= addr_cnt;
            wr.data <= s_data;
            if (last) state <= CHECK;
          end
        end
        CHECK: begin
          if (abort) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (accept) begin
            err   <= (s_data != sum);
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_loader.sv
// tb/tb_wb_loader.sv - self-checking bench for wb_loader against a word-index reference model
module tb_wb_loader;
  import wb_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              layer_sel;
  logic              abort;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              err;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [DATA_W-1:0] words [0:L1_BANKS*L1_DEPTH-1];

  wb_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .layer_sel (layer_sel),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = valid every cycle, 1 = valid on alternate cycles, 2 = random valid.
  // abort_at: 1-based index of the data word that carries abort (0 = never).
  // reset_at / restart_at: data word index at which reset / a stray start occurs (-1 = never).
  task automatic do_load(input bit lsel, input int mode, input int abort_at, input int reset_at,
                         input int restart_at, input bit bad_sum, input bit seq_data);
    int nb, dep, base, total, idx, cyc;
    logic [DATA_W-1:0] sum;
    bit v, ab, fin, exp_err;
    nb    = lsel ? L2_BANKS : L1_BANKS;
    dep   = lsel ? L2_DEPTH : L1_DEPTH;
    base  = lsel ? L1_BANKS : 0;
    total = nb * dep;
    sum   = '0;
    for (int i = 0; i < total; i++) begin
      words[i] = seq_data ? DATA_W'(i + 1) : DATA_W'($urandom);
      sum += words[i];
    end
    exp_err = bad_sum;

    start = 1'b1; layer_sel = lsel; abort = 1'b0; s_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("s_ready_in_load", s_ready, 1);
    chk("err_cleared_by_start", err, 0);

    idx = 0; cyc = 0; fin = 0;
    while (!fin) begin
      if (cyc > 4 * total + 64) begin
        chk("timeout", 0, 1);
        fin = 1;
      end else begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        s_valid = v;
        s_data  = (idx < total) ? words[idx] : (bad_sum ? sum - 1 : sum);
        ab      = v && (idx + 1 == abort_at);
        abort   = ab;
        if (idx == restart_at) begin
          start = 1'b1; layer_sel = ~lsel;
        end
        if (idx == reset_at) begin
          reset = 1'b1;
          tick();
          reset = 1'b0; start = 1'b0; s_valid = 1'b0; abort = 1'b0;
          chk("rst_wr_en", wr_en, 0);
          chk("rst_wr_bank", wr_bank, 0);
          chk("rst_wr_addr", wr_addr, 0);
          chk("rst_wr_data", wr_data, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_err", err, 0);
          chk("rst_s_ready", s_ready, 0);
          exp_err = 0;
          fin = 1;
        end else begin
          tick();
          abort = 1'b0; start = 1'b0; layer_sel = lsel;
          if (ab) begin
            chk("abort_wr_en", wr_en, 0);
            chk("abort_busy", busy, 0);
            chk("abort_err", err, 1);
            chk("abort_done", done, 0);
            chk("abort_write_count", idx, abort_at - 1);
            exp_err = 1;
            fin = 1;
          end else if (v && idx < total) begin
            chk("wr_en", wr_en, 1);
            chk("wr_bank_addr_data", {wr_bank, wr_addr, wr_data},
                {BANK_W'(base + idx / dep), ADDR_W'(idx % dep), words[idx]});
            idx++;
          end else if (v) begin
            chk("checksum_not_written", wr_en, 0);
            chk("done_pulse", done, 1);
            chk("checksum_err", err, bad_sum);
            chk("busy_after_done", busy, 0);
            chk("write_count", idx, total);
            fin = 1;
          end else begin
            chk("gap_no_write", wr_en, 0);
            chk("gap_no_done", done, 0);
          end
        end
        cyc++;
      end
    end
    s_valid = 1'b0;
    tick();
    chk("done_single_cycle", done, 0);
    chk("err_after_load", err, exp_err);
    chk("idle_after_load", busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; layer_sel = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_data = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_bank", wr_bank, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_s_ready", s_ready, 0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_err", err, 0);

    do_load(1'b1, 0, 0, -1, -1, 1'b0, 1'b1);
    do_load(1'b1, 0, 0, -1, -1, 1'b1, 1'b1);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("err_sticky_in_idle", err, 1);
    chk("idle_abort_no_busy", busy, 0);

    do_load(1'b0, 1, 0, -1, -1, 1'b0, 1'b0);
    do_load(1'b1, 0, 100, -1, -1, 1'b0, 1'b1);

    start = 1'b1; abort = 1'b1; layer_sel = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_wins_busy", busy, 1);
    chk("start_wins_err", err, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("load_abort_busy", busy, 0);
    chk("load_abort_err", err, 1);

    do_load(1'b1, 2, 0, -1, 50, 1'b0, 1'b0);
    do_load(1'b1, 0, 0, 10, -1, 1'b0, 1'b1);
    do_load(1'b1, 2, 0, -1, -1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
